// File: rtl/x25519_ise_sigma_seq.sv
// rtl/x25519_ise_sigma_seq.sv - iterated rotate-XOR sigma coprocessor, valid/ready handshake
// rd = f^(iter+1)(rs1), f(x) = x ^ ror(x,A) ^ ror(x,B), one application per BUSY cycle.
module x25519_ise_sigma_seq #(
  parameter int XLEN   = 64,
  parameter int ITER_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   rs1,
  input  logic [4:0]        imm,
  input  logic              op_sigma,
  input  logic [ITER_W-1:0] iter,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   rd,
  output logic              err
);

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("x25519_ise_sigma_seq: XLEN must be 32 or 64");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [ITER_W-1:0] cnt_q, cnt_d;
  logic [2:0]        sel_q, sel_d;
  logic              err_q, err_d;

  function automatic logic [XLEN-1:0] ror(input logic [XLEN-1:0] x, input int unsigned s);
    return (x >> s) | (x << (XLEN - s));
  endfunction

  // sel is only ever 0..4 here; illegal selects never reach BUSY.
  function automatic logic [XLEN-1:0] sigma_f(input logic [XLEN-1:0] x, input logic [2:0] sel);
    int unsigned a;
    int unsigned b;
    a = 1;
    b = 8;
    if (XLEN == 64) begin
      case (sel)
        3'd0:    begin a = 19; b = 28; end
        3'd1:    begin a = 61; b = 39; end
        3'd2:    begin a = 1;  b = 6;  end
        3'd3:    begin a = 10; b = 17; end
        default: begin a = 7;  b = 41; end
      endcase
    end else begin
      case (sel)
        3'd0:    begin a = 2;  b = 13; end
        3'd1:    begin a = 6;  b = 11; end
        3'd2:    begin a = 7;  b = 18; end
        3'd3:    begin a = 17; b = 19; end
        default: begin a = 1;  b = 8;  end
      endcase
    end
    return x ^ ror(x, a) ^ ror(x, b);
  endfunction

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    err_d     = err_q;
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d = rs1;
          cnt_d = iter;
          sel_d = imm[2:0];
          err_d = 1'b0;
          if (!op_sigma || imm > 5'd4) begin
            acc_d   = '0;
            err_d   = op_sigma && (imm > 5'd4);
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        acc_d = sigma_f(acc_q, sel_q);
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over both accept and handoff.
    if (flush) begin
      state_d = IDLE;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  assign rd  = out_valid ? acc_q : '0;
  assign err = out_valid & err_q;

endmodule

// File: tb/tb_x25519_ise_sigma_seq.sv
// tb/tb_x25519_ise_sigma_seq.sv - self-checking bench, XLEN=64 and XLEN=32 instances in lockstep
// Both instances see the same request (32-bit one uses rs1[31:0]); results checked against a model.
module tb_x25519_ise_sigma_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] rs1 = '0;
  logic [4:0]  imm = '0;
  logic        op_sigma = 1'b0;
  logic [3:0]  iter = '0;
  logic        out_ready = 1'b0;

  logic        in_ready64, out_valid64, err64;
  logic [63:0] rd64;
  logic        in_ready32, out_valid32, err32;
  logic [31:0] rd32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  x25519_ise_sigma_seq #(.XLEN(64), .ITER_W(4)) u64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .rs1(rs1), .imm(imm), .op_sigma(op_sigma), .iter(iter), .out_valid(out_valid64),
    .out_ready(out_ready), .rd(rd64), .err(err64)
  );

  x25519_ise_sigma_seq #(.XLEN(32), .ITER_W(4)) u32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .rs1(rs1[31:0]), .imm(imm), .op_sigma(op_sigma), .iter(iter), .out_valid(out_valid32),
    .out_ready(out_ready), .rd(rd32), .err(err32)
  );

  // Reference: rotate amounts straight from the algorithm definition, applied iter+1 times.
  function automatic logic [63:0] ref_ror(input logic [63:0] x, input int s, input int w);
    logic [63:0] mask;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    x = x & mask;
    return ((x >> s) | (x << (w - s))) & mask;
  endfunction

  function automatic logic [63:0] ref_rd(input logic [63:0] x, input int im, input bit op,
                                         input int it, input int w);
    int a64 [5] = '{19, 61, 1, 10, 7};
    int b64 [5] = '{28, 39, 6, 17, 41};
    int a32 [5] = '{2, 6, 7, 17, 1};
    int b32 [5] = '{13, 11, 18, 19, 8};
    logic [63:0] y;
    int a;
    int b;
    if (!op || im > 4) return 64'd0;
    a = (w == 64) ? a64[im] : a32[im];
    b = (w == 64) ? b64[im] : b32[im];
    y = (w == 64) ? x : {32'd0, x[31:0]};
    for (int k = 0; k <= it; k++) y = y ^ ref_ror(y, a, w) ^ ref_ror(y, b, w);
    return y;
  endfunction

  function automatic int ref_lat(input int im, input bit op, input int it);
    return (op && im <= 4) ? it + 2 : 1;
  endfunction

  task automatic drive_req(input logic [63:0] d, input int im, input bit op, input int it);
    rs1      = d;
    imm      = im[4:0];
    op_sigma = op;
    iter     = it[3:0];
    in_valid = 1'b1;
  endtask

  // Called at a negedge with a request driven; returns edges from accept (inclusive) to out_valid.
  task automatic wait_result(output int lat, output logic [63:0] r64, output logic [31:0] r32,
                             output logic e64, output logic e32, output logic v32);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid64 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    r64 = rd64;
    r32 = rd32;
    e64 = err64;
    e32 = err32;
    v32 = out_valid32;
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_and_check(input string name, input logic [63:0] d, input int im,
                               input bit op, input int it);
    int lat;
    logic [63:0] r64;
    logic [31:0] r32;
    logic e64, e32, v32;
    logic [63:0] x64, x32;
    x64 = ref_rd(d, im, op, it, 64);
    x32 = ref_rd(d, im, op, it, 32);
    drive_req(d, im, op, it);
    wait_result(lat, r64, r32, e64, e32, v32);
    checks++;
    if (lat !== ref_lat(im, op, it)) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, ref_lat(im, op, it));
    end
    checks++;
    if (r64 !== x64 || e64 !== (op && im > 4)) begin
      errors++;
      $display("FAIL %s rd64/err: got %h/%b expected %h/%b", name, r64, e64, x64, op && im > 4);
    end
    checks++;
    if (v32 !== 1'b1 || r32 !== x32[31:0] || e32 !== (op && im > 4)) begin
      errors++;
      $display("FAIL %s rd32/err: got v=%b %h/%b expected v=1 %h/%b", name, v32, r32, e32,
               x32[31:0], op && im > 4);
    end
    handoff();
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready64 !== 1'b1 || out_valid64 !== 1'b0 || rd64 !== 64'd0 || err64 !== 1'b0 ||
        in_ready32 !== 1'b1 || out_valid32 !== 1'b0 || rd32 !== 32'd0 || err32 !== 1'b0) begin
      errors++;
      $display("FAIL reset: got rdy=%b ov=%b rd=%h err=%b expected 1 0 0 0",
               in_ready64, out_valid64, rd64, err64);
    end
  endtask

  task automatic test_known_vectors();
    int lat;
    logic [63:0] r64;
    logic [31:0] r32;
    logic e64, e32, v32;
    drive_req(64'h1, 2, 1'b1, 0);
    wait_result(lat, r64, r32, e64, e32, v32);
    checks++;
    if (lat !== 2 || r64 !== 64'h8400_0000_0000_0001 || e64 !== 1'b0) begin
      errors++;
      $display("FAIL vec_imm2_it0: got lat=%0d rd=%h err=%b expected 2 8400000000000001 0",
               lat, r64, e64);
    end
    handoff();
    drive_req(64'h1, 2, 1'b1, 1);
    wait_result(lat, r64, r32, e64, e32, v32);
    checks++;
    if (lat !== 3 || r64 !== 64'h4010_0000_0000_0001) begin
      errors++;
      $display("FAIL vec_imm2_it1: got lat=%0d rd=%h expected 3 4010000000000001", lat, r64);
    end
    handoff();
    drive_req(64'h1, 4, 1'b1, 0);
    wait_result(lat, r64, r32, e64, e32, v32);
    checks++;
    if (r32 !== 32'h8100_0001 || e32 !== 1'b0 || v32 !== 1'b1) begin
      errors++;
      $display("FAIL vec32_imm4: got rd=%h err=%b v=%b expected 81000001 0 1", r32, e32, v32);
    end
    handoff();
  endtask

  task automatic test_illegal_and_zero();
    run_and_check("imm5_sigma", 64'hDEAD_BEEF_0123_4567, 5, 1'b1, 3);
    run_and_check("imm31_sigma", 64'hFFFF_FFFF_FFFF_FFFF, 31, 1'b1, 0);
    run_and_check("imm5_nosigma", 64'hDEAD_BEEF_0123_4567, 5, 1'b0, 3);
    run_and_check("imm1_nosigma", 64'h1234_5678_9ABC_DEF0, 1, 1'b0, 7);
  endtask

  task automatic test_max_iter();
    run_and_check("max_iter_imm0", 64'h0000_0000_0000_0001, 0, 1'b1, 15);
    run_and_check("max_iter_imm3", 64'hA5A5_5A5A_0F0F_F0F0, 3, 1'b1, 15);
  endtask

  task automatic test_hold_back_to_back();
    int lat;
    logic [63:0] r64;
    logic [31:0] r32;
    logic e64, e32, v32;
    logic [63:0] x_a, x_b;
    int bad;
    x_a = ref_rd(64'h0F0F_0000_1234_8001, 1, 1'b1, 2, 64);
    x_b = ref_rd(64'h7777_0000_0000_0003, 3, 1'b1, 1, 64);
    drive_req(64'h0F0F_0000_1234_8001, 1, 1'b1, 2);
    wait_result(lat, r64, r32, e64, e32, v32);
    // Next request presented while DONE; it must not be taken until IDLE.
    drive_req(64'h7777_0000_0000_0003, 3, 1'b1, 1);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (out_valid64 !== 1'b1 || rd64 !== x_a || in_ready64 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_stable: got %0d unstable cycles (last rd=%h) expected 0 (rd=%h)",
               bad, rd64, x_a);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid64 !== 1'b0 || in_ready64 !== 1'b1 || rd64 !== 64'd0) begin
      errors++;
      $display("FAIL hold_release: got ov=%b rdy=%b rd=%h expected 0 1 0",
               out_valid64, in_ready64, rd64);
    end
    wait_result(lat, r64, r32, e64, e32, v32);
    checks++;
    if (lat !== 3 || r64 !== x_b) begin
      errors++;
      $display("FAIL back_to_back: got lat=%0d rd=%h expected 3 %h", lat, r64, x_b);
    end
    handoff();
  endtask

  task automatic test_flush_rst();
    int pulses;
    drive_req(64'h1, 0, 1'b1, 15);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid64) pulses++;
    end
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (in_ready64 !== 1'b1 || out_valid64 !== 1'b0 || err64 !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: got rdy=%b ov=%b err=%b expected 1 0 0",
               in_ready64, out_valid64, err64);
    end
    repeat (20) begin
      @(negedge clk);
      if (out_valid64 || out_valid32) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL flush_no_pulse: got %0d valid cycles expected 0", pulses);
    end
    run_and_check("after_flush", 64'hCAFE_F00D_0000_0001, 2, 1'b1, 4);

    drive_req(64'h1, 4, 1'b1, 15);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready64 !== 1'b1 || out_valid64 !== 1'b0 || rd64 !== 64'd0 ||
        in_ready32 !== 1'b1 || out_valid32 !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: got rdy=%b ov=%b rd=%h expected 1 0 0",
               in_ready64, out_valid64, rd64);
    end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid64 || out_valid32) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL rst_no_pulse: got %0d valid cycles expected 0", pulses);
    end
    run_and_check("after_rst", 64'h0123_4567_89AB_CDEF, 4, 1'b1, 2);
  endtask

  task automatic test_random();
    logic [63:0] d;
    int im, it;
    bit op;
    for (int n = 0; n < 40; n++) begin
      d  = {$urandom, $urandom};
      im = $urandom_range(0, 6);
      op = ($urandom_range(0, 7) != 0);
      it = $urandom_range(0, 15);
      run_and_check($sformatf("rand%0d", n), d, im, op, it);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_known_vectors();
    test_illegal_and_zero();
    test_max_iter();
    test_hold_back_to_back();
    test_flush_rst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
